// File: rtl/i2c_slave_regs.sv
// I2C register-access slave: 7-bit device address, pointer byte, then an auto-incrementing
// burst of writes or reads against a user register file behind a strobe/address/data port.
`timescale 1ns/1ps
module i2c_slave_regs #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_W     = 8,
    parameter int FILTER_LEN = 3,
    parameter int AUTO_INC   = 1,
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [6:0]        my_dev_address,
    input  logic              scl,
    input  logic              sda_i,
    output logic              sda_o,
    output logic              sda_oen,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [AW-1:0]     rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_strobe,
    output logic              busy,
    output logic              addr_err
);
    generate
        if (DATA_W != 8 || FILTER_LEN < 1 || FILTER_LEN > 15 || NUM_REGS < 1 || NUM_REGS > 256) begin : g_param_check
            $error("i2c_slave_regs: unsupported parameter set");
        end
    endgenerate

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] DEV_ADDR = 4'd1;
    localparam logic [3:0] ACK_ADDR = 4'd2;
    localparam logic [3:0] REG_PTR  = 4'd3;
    localparam logic [3:0] ACK_PTR  = 4'd4;
    localparam logic [3:0] WR_DATA  = 4'd5;
    localparam logic [3:0] ACK_WR   = 4'd6;
    localparam logic [3:0] RD_DATA  = 4'd7;
    localparam logic [3:0] RD_ACK   = 4'd8;
    localparam logic [3:0] IGNORE   = 4'd9;

    // Channel 0 is SCL, channel 1 is SDA; both idle high so everything resets to 1.
    logic [1:0] pin_raw;
    wire  [1:0] filt;
    assign pin_raw = {sda_i, scl};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            logic [1:0] sync_q;
            logic [3:0] cnt_q;
            logic       filt_q;
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    sync_q <= 2'b11;
                    cnt_q  <= '0;
                    filt_q <= 1'b1;
                end else begin
                    sync_q <= {sync_q[0], pin_raw[gi]};
                    if (sync_q[1] == filt_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
                        filt_q <= sync_q[1];
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
            end
            assign filt[gi] = filt_q;
        end
    endgenerate

    logic scl_f, sda_f, scl_prev_q, sda_prev_q;
    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_f     = filt[0];
    assign sda_f     = filt[1];
    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

    logic [3:0]        state_q, state_d, bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              phase_q, phase_d, nack_q, nack_d, oen_q, oen_d;
    logic [AW-1:0]     ptr_q, ptr_d, wr_addr_q, wr_addr_d, ptr_adv;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d, rd_strobe_q, rd_strobe_d;
    logic              busy_q, busy_d, addr_err_q, addr_err_d;
    logic [7:0]        byte_in;
    logic              do_load;

    assign byte_in = {shift_q[6:0], sda_f};
    assign ptr_adv = (AUTO_INC == 0) ? ptr_q :
                     (ptr_q == AW'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        phase_d     = phase_q;
        nack_d      = nack_q;
        oen_d       = oen_q;
        ptr_d       = ptr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;
        wr_en_d     = 1'b0;
        rd_strobe_d = 1'b0;
        addr_err_d  = 1'b0;
        do_load     = 1'b0;
        if (start_det) begin
            state_d   = DEV_ADDR;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            oen_d     = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d = IDLE;
            oen_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                DEV_ADDR, REG_PTR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                            if (state_q == DEV_ADDR) begin
                                state_d = (byte_in[7:1] == my_dev_address) ? ACK_ADDR : IDLE;
                            end else if (state_q == REG_PTR) begin
                                if (32'(byte_in) < NUM_REGS) begin
                                    ptr_d   = byte_in[AW-1:0];
                                    state_d = ACK_PTR;
                                end else begin
                                    addr_err_d = 1'b1;
                                    state_d    = IGNORE;
                                end
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = byte_in;
                                ptr_d     = ptr_adv;
                                state_d   = ACK_WR;
                            end
                        end
                    end
                end
                // First fall opens the ACK bit, second fall closes it.
                ACK_ADDR, ACK_PTR, ACK_WR: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            oen_d   = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            bit_cnt_d = '0;
                            oen_d     = 1'b0;
                            if (state_q == ACK_ADDR && shift_q[0]) begin
                                do_load = 1'b1;
                            end else begin
                                state_d = (state_q == ACK_ADDR) ? REG_PTR : WR_DATA;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oen_d     = 1'b0;
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oen_d   = ~shift_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        nack_d  = sda_f;
                        phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        phase_d = 1'b0;
                        if (nack_q) state_d = IGNORE;
                        else        do_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (do_load) begin
            shift_d     = rd_data;
            oen_d       = ~rd_data[7];
            rd_strobe_d = 1'b1;
            ptr_d       = ptr_adv;
            bit_cnt_d   = '0;
            state_d     = RD_DATA;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            phase_q     <= 1'b0;
            nack_q      <= 1'b0;
            oen_q       <= 1'b0;
            ptr_q       <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            scl_prev_q  <= scl_f;
            sda_prev_q  <= sda_f;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            phase_q     <= phase_d;
            nack_q      <= nack_d;
            oen_q       <= oen_d;
            ptr_q       <= ptr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            rd_strobe_q <= rd_strobe_d;
            busy_q      <= busy_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign sda_o     = 1'b0;
    assign sda_oen   = oen_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_addr   = ptr_q;
    assign rd_strobe = rd_strobe_q;
    assign busy      = busy_q;
    assign addr_err  = addr_err_q;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master on a wired-AND bus with two slaves
// (0x42 auto-increment, 0x50 fixed pointer); register-port events checked from queues.
`timescale 1ns/1ps
module tb_i2c_slave_regs;
    localparam int Q = 100;  // quarter SCL period, 10 clk

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst, scl, sda_m, glitch_n, sda_line;
    logic sda_o0, oen0, wr_en0, rd_strobe0, busy0, addr_err0;
    logic sda_o1, oen1, wr_en1, rd_strobe1, busy1, addr_err1;
    logic [3:0] wr_addr0, rd_addr0, wr_addr1, rd_addr1;
    logic [7:0] wr_data0, rd_data0, rd_p1, wr_data1, rd_data1;

    assign sda_line = sda_m & glitch_n & (oen0 ? sda_o0 : 1'b1) & (oen1 ? sda_o1 : 1'b1);
    assign rd_data1 = 8'h20 + {4'h0, rd_addr1};

    // Register file read port with two clocks of latency.
    always @(posedge clk) begin
        rd_p1    <= 8'h10 + {4'h0, rd_addr0};
        rd_data0 <= rd_p1;
    end

    i2c_slave_regs #(.NUM_REGS(16), .DATA_W(8), .FILTER_LEN(3), .AUTO_INC(1)) dut0 (
        .clk(clk), .n_rst(n_rst), .my_dev_address(7'h42), .scl(scl), .sda_i(sda_line),
        .sda_o(sda_o0), .sda_oen(oen0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_strobe(rd_strobe0), .busy(busy0),
        .addr_err(addr_err0));

    i2c_slave_regs #(.NUM_REGS(16), .DATA_W(8), .FILTER_LEN(3), .AUTO_INC(0)) dut1 (
        .clk(clk), .n_rst(n_rst), .my_dev_address(7'h50), .scl(scl), .sda_i(sda_line),
        .sda_o(sda_o1), .sda_oen(oen1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_strobe(rd_strobe1), .busy(busy1),
        .addr_err(addr_err1));

    typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
    wr_t exp_wr0[$], exp_wr1[$];
    int  exp_rd0[$], exp_err0[$];
    wr_t e0, e1;
    int  tok;
    int  checks = 0, errors = 0;
    logic oen_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    // Monitor: pops an expectation whenever a DUT presents a register-port event.
    always @(negedge clk) begin
        if (oen0) oen_seen = 1'b1;
        if (n_rst === 1'b1) begin
            if (wr_en0) begin
                if (exp_wr0.size() == 0) unexpected("wr0_unexpected");
                else begin
                    e0 = exp_wr0.pop_front();
                    check("wr0_addr", 32'(wr_addr0), 32'(e0.a));
                    check("wr0_data", 32'(wr_data0), 32'(e0.d));
                    $display("  event wr0 addr=%0d data=0x%02h", wr_addr0, wr_data0);
                end
            end
            if (wr_en1) begin
                if (exp_wr1.size() == 0) unexpected("wr1_unexpected");
                else begin
                    e1 = exp_wr1.pop_front();
                    check("wr1_addr", 32'(wr_addr1), 32'(e1.a));
                    check("wr1_data", 32'(wr_data1), 32'(e1.d));
                    $display("  event wr1 addr=%0d data=0x%02h", wr_addr1, wr_data1);
                end
            end
            if (rd_strobe0) begin
                if (exp_rd0.size() == 0) unexpected("rd0_strobe_unexpected");
                else begin tok = exp_rd0.pop_front(); checks++; end
            end
            if (addr_err0) begin
                if (exp_err0.size() == 0) unexpected("addr_err0_unexpected");
                else begin tok = exp_err0.pop_front(); checks++; end
            end
            if (rd_strobe1) unexpected("rd1_strobe_unexpected");
            if (addr_err1)  unexpected("addr_err1_unexpected");
        end
    end

    task automatic bit_io(input logic b, output logic r);
        sda_m = b; #Q; scl = 1'b1; #Q; r = sda_line; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
    endtask

    task automatic send(input string name, input logic [7:0] b, input logic exp_nack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(b[i], r);
        bit_io(1'b1, r);
        check(name, 32'(r), 32'(exp_nack));
    endtask

    task automatic recv(input string name, input logic nack, input logic [7:0] exp);
        logic r;
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) begin bit_io(1'b1, r); d[i] = r; end
        bit_io(nack, r);
        check(name, 32'(d), 32'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r;
        n_rst = 1'b0; scl = 1'b1; sda_m = 1'b1; glitch_n = 1'b1;
        idle(5);
        check("rst_oen", 32'(oen0), 0);
        check("rst_sda_o", 32'(sda_o0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_wr_en", 32'(wr_en0), 0);
        check("rst_rd_addr", 32'(rd_addr0), 0);
        check("rst_wr_data", 32'(wr_data0), 0);
        n_rst = 1'b1;
        idle(20);

        $display("txn write dev=0x42 ptr=0x03 data=A5,5A");
        i2c_start();
        send("t1_addr_ack", 8'h84, 1'b0);
        send("t1_ptr_ack", 8'h03, 1'b0);
        exp_wr0.push_back('{4'd3, 8'hA5});
        send("t1_d0_ack", 8'hA5, 1'b0);
        exp_wr0.push_back('{4'd4, 8'h5A});
        send("t1_d1_ack", 8'h5A, 1'b0);
        check("t1_busy_mid", 32'(busy0), 1);
        i2c_stop();
        idle(20);
        check("t1_busy_after_stop", 32'(busy0), 0);
        check("t1_writes_seen", 32'(exp_wr0.size()), 0);

        $display("txn write dev=0x42 ptr=0x0F data=11,22 (wrap)");
        i2c_start();
        send("t2_addr_ack", 8'h84, 1'b0);
        send("t2_ptr_ack", 8'h0F, 1'b0);
        exp_wr0.push_back('{4'd15, 8'h11});
        send("t2_d0_ack", 8'h11, 1'b0);
        exp_wr0.push_back('{4'd0, 8'h22});
        send("t2_d1_ack", 8'h22, 1'b0);
        i2c_stop();
        idle(20);
        check("t2_writes_seen", 32'(exp_wr0.size()), 0);
        check("t2_ptr_after_wrap", 32'(rd_addr0), 1);

        $display("txn write dev=0x50 ptr=0x0F data=33,44 (no auto-inc)");
        i2c_start();
        send("t2b_addr_ack", 8'hA0, 1'b0);
        send("t2b_ptr_ack", 8'h0F, 1'b0);
        exp_wr1.push_back('{4'd15, 8'h33});
        send("t2b_d0_ack", 8'h33, 1'b0);
        exp_wr1.push_back('{4'd15, 8'h44});
        send("t2b_d1_ack", 8'h44, 1'b0);
        i2c_stop();
        idle(20);
        check("t2b_writes_seen", 32'(exp_wr1.size()), 0);
        check("t2b_ptr_held", 32'(rd_addr1), 15);

        $display("txn combined read dev=0x42 ptr=0x07, 3 bytes");
        i2c_start();
        send("t3_addr_w_ack", 8'h84, 1'b0);
        send("t3_ptr_ack", 8'h07, 1'b0);
        i2c_start();
        repeat (3) exp_rd0.push_back(1);
        send("t3_addr_r_ack", 8'h85, 1'b0);
        recv("t3_byte0", 1'b0, 8'h17);
        recv("t3_byte1", 1'b0, 8'h18);
        recv("t3_byte2", 1'b1, 8'h19);
        idle(10);
        check("t3_released_after_nack", 32'(oen0), 0);
        i2c_stop();
        idle(20);
        check("t3_strobes_seen", 32'(exp_rd0.size()), 0);
        check("t3_ptr_after_reads", 32'(rd_addr0), 10);

        $display("txn address mismatch dev=0x43");
        oen_seen = 1'b0;
        i2c_start();
        send("t4_addr_nack", 8'h86, 1'b1);
        send("t4_data_nack", 8'h01, 1'b1);
        i2c_stop();
        idle(20);
        check("t4_never_driven", 32'(oen_seen), 0);
        check("t4_ptr_unchanged", 32'(rd_addr0), 10);

        $display("txn bad pointer dev=0x42 ptr=0x20");
        exp_err0.push_back(1);
        i2c_start();
        send("t5_addr_ack", 8'h84, 1'b0);
        send("t5_ptr_nack", 8'h20, 1'b1);
        send("t5_data_nack", 8'h99, 1'b1);
        i2c_stop();
        idle(20);
        check("t5_addr_err_seen", 32'(exp_err0.size()), 0);
        check("t5_ptr_unchanged", 32'(rd_addr0), 10);

        $display("txn SDA glitches of 1 and 2 clk while SCL high");
        for (int g = 1; g <= 2; g++) begin
            glitch_n = 1'b0;
            idle(g);
            glitch_n = 1'b1;
            idle(20);
            check($sformatf("t6_no_start_glitch%0d", g), 32'(busy0), 0);
        end

        $display("txn reset during read byte, then clean write");
        exp_rd0.push_back(1);
        i2c_start();
        send("t7_addr_r_ack", 8'h85, 1'b0);
        sda_m = 1'b1; #Q; scl = 1'b1; #(Q/2);
        check("t7_driving_bit7", 32'(oen0), 1);
        n_rst = 1'b0;
        #1;
        check("t7_oen_async_release", 32'(oen0), 0);
        #(Q/2 - 1);
        n_rst = 1'b1;
        scl = 1'b0; #Q;
        for (int i = 0; i < 8; i++) bit_io(1'b1, r);
        i2c_stop();
        idle(20);
        check("t7_busy_after_reset", 32'(busy0), 0);
        check("t7_ptr_reset", 32'(rd_addr0), 0);
        check("t7_strobe_seen", 32'(exp_rd0.size()), 0);
        i2c_start();
        send("t7_clean_addr_ack", 8'h84, 1'b0);
        send("t7_clean_ptr_ack", 8'h05, 1'b0);
        exp_wr0.push_back('{4'd5, 8'h33});
        send("t7_clean_d0_ack", 8'h33, 1'b0);
        i2c_stop();
        idle(20);
        check("t7_clean_write_seen", 32'(exp_wr0.size()), 0);
        check("t7_clean_ptr", 32'(rd_addr0), 6);

        idle(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
